// File: rtl/tcb_lib_pkg.sv
// Shared TCB library types and helpers used by the arbiter slice.
package tcb_lib_pkg;

    // Arbiter lock state: IDLE searches for a requester, LOCK holds the grant until rdy.
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int unsigned DLY_MAX = 8;

    // Select width; a single port still needs a one-bit select.
    function automatic int unsigned sel_width(input int unsigned pn);
        return (pn > 1) ? $clog2(pn) : 1;
    endfunction

endpackage

// File: rtl/tcb_lib_arbiter_if.sv
// Request/grant/select bundle between TCB managers, arbiter and shared subordinate.
interface tcb_lib_arbiter_if
    import tcb_lib_pkg::*;
#(
    parameter int unsigned PN = 2
) ();

    localparam int unsigned PL = sel_width(PN);

    logic [PN-1:0] req;
    logic          rdy;
    logic [PN-1:0] gnt;
    logic [PL-1:0] sel;
    logic [PL-1:0] rsp_sel;

    modport master (output req, rdy, input gnt, sel, rsp_sel);
    modport slave  (input req, rdy, output gnt, sel, rsp_sel);

endinterface

// File: rtl/tcb_lib_arbiter_rr.sv
// Wrapped priority search: first requester at or above ptr, else first below ptr.
module tcb_lib_arbiter_rr #(
    parameter int unsigned PN = 2,
    parameter int unsigned PL = 1
) (
    input  logic [PN-1:0] req_i,
    input  logic [PL-1:0] ptr_i,
    output logic [PN-1:0] gnt_o,
    output logic [PL-1:0] idx_o,
    output logic          any_o
);

    // Two ordered passes replace a modulo index and give the wrap PN-1 -> 0.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < PN; i++) begin
            if (!any_o && req_i[i] && (PL'(i) >= ptr_i)) begin
                any_o    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = PL'(i);
            end
        end
        for (int i = 0; i < PN; i++) begin
            if (!any_o && req_i[i] && (PL'(i) < ptr_i)) begin
                any_o    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = PL'(i);
            end
        end
    end

endmodule

// File: rtl/tcb_lib_arbiter.sv
// Round-robin TCB arbiter with grant lock and delayed response-path select.
module tcb_lib_arbiter
    import tcb_lib_pkg::*;
#(
    parameter int unsigned PN  = 2,
    parameter int unsigned DLY = 1
) (
    input  logic              clk,
    input  logic              rst,
    tcb_lib_arbiter_if.slave  arb
);

    localparam int unsigned PL = sel_width(PN);

    if (PN == 1) begin : g_single
        assign arb.gnt     = rst ? arb.req : '0;
        assign arb.sel     = '0;
        assign arb.rsp_sel = '0;
    end else begin : g_multi
        arb_state_t    state_q, state_d;
        logic [PL-1:0] ptr_q, ptr_d;
        logic [PL-1:0] lock_q, lock_d;
        logic [PL-1:0] last_q, last_d;
        logic [PN-1:0] rr_gnt;
        logic [PL-1:0] rr_idx;
        logic          rr_any;
        logic [PN-1:0] gnt_c;
        logic [PL-1:0] sel_c;
        logic [PL-1:0] sel_o;
        logic          trn_c;
        logic          req_lock_c;

        tcb_lib_arbiter_rr #(.PN(PN), .PL(PL)) u_rr (
            .req_i (arb.req),
            .ptr_i (ptr_q),
            .gnt_o (rr_gnt),
            .idx_o (rr_idx),
            .any_o (rr_any)
        );

        // State register: lock state, round-robin pointer, locked and last index.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= IDLE;
                ptr_q   <= '0;
                lock_q  <= '0;
                last_q  <= '0;
            end else begin
                state_q <= state_d;
                ptr_q   <= ptr_d;
                lock_q  <= lock_d;
                last_q  <= last_d;
            end
        end

        // Next state: lock on an unaccepted grant, release on transfer or dropped request.
        always_comb begin
            state_d = state_q;
            ptr_d   = ptr_q;
            lock_d  = lock_q;
            last_d  = last_q;
            case (state_q)
                IDLE: begin
                    if (rr_any && !arb.rdy) begin
                        state_d = LOCK;
                        lock_d  = rr_idx;
                    end
                end
                LOCK: begin
                    if (trn_c || !req_lock_c) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (trn_c) ptr_d = (sel_c == PL'(PN - 1)) ? '0 : sel_c + PL'(1);
            if (|gnt_c) last_d = sel_c;
        end

        // Outputs: locked index wins, else search result, else the last granted index.
        always_comb begin
            gnt_c = '0;
            sel_c = last_q;
            if (state_q == LOCK) begin
                for (int i = 0; i < PN; i++) gnt_c[i] = (PL'(i) == lock_q);
                sel_c = lock_q;
            end else if (rr_any) begin
                gnt_c = rr_gnt;
                sel_c = rr_idx;
            end
        end

        assign req_lock_c = |(arb.req & gnt_c);
        assign trn_c      = req_lock_c && arb.rdy;
        assign sel_o      = rst ? sel_c : '0;
        assign arb.gnt    = rst ? gnt_c : '0;
        assign arb.sel    = sel_o;

        lock_hold_a: assert property (@(posedge clk) disable iff (!rst)
            (state_q == LOCK) |-> req_lock_c);

        if (DLY == 0) begin : g_rsp_comb
            assign arb.rsp_sel = sel_o;
        end else begin : g_rsp_pipe
            logic [PL-1:0] pipe_q [DLY];
            logic [PL-1:0] pipe_d [DLY];

            // Stage 0 captures sel on transfer; later stages shift every cycle.
            always_comb begin
                pipe_d = pipe_q;
                if (trn_c) pipe_d[0] = sel_o;
                for (int i = 1; i < DLY; i++) pipe_d[i] = pipe_q[i-1];
            end

            // Response select pipeline registers.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DLY; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign arb.rsp_sel = pipe_q[DLY-1];
        end
    end

endmodule

// File: tb/tb_tcb_lib_arbiter.sv
// Bench: round-robin/lock reference model, directed scenarios and random traffic.
module tb_tcb_lib_arbiter;

    localparam int unsigned PN  = 4;
    localparam int unsigned DLY = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [PN-1:0] req;
    logic          rdy;
    logic [1:0]    req2;
    logic          rdy2;

    tcb_lib_arbiter_if #(.PN(PN)) bus_a ();
    tcb_lib_arbiter_if #(.PN(PN)) bus_b ();
    tcb_lib_arbiter_if #(.PN(2))  bus_c ();

    assign bus_a.req = req;
    assign bus_a.rdy = rdy;
    assign bus_b.req = req;
    assign bus_b.rdy = rdy;
    assign bus_c.req = req2;
    assign bus_c.rdy = rdy2;

    tcb_lib_arbiter #(.PN(PN), .DLY(DLY)) dut_a (.clk(clk), .rst(rst), .arb(bus_a.slave));
    tcb_lib_arbiter #(.PN(PN), .DLY(0))   dut_b (.clk(clk), .rst(rst), .arb(bus_b.slave));
    tcb_lib_arbiter #(.PN(2),  .DLY(1))   dut_c (.clk(clk), .rst(rst), .arb(bus_c.slave));

    // Reference model: held grant, round-robin pointer, last granted, transfer history.
    bit  m_hold;
    int  m_hidx;
    int  m_ptr;
    int  m_last;
    int  hist[$];
    int  wait_n[PN];
    int  last_x;
    bit  pend[PN];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = 1'b0;
        m_hidx = 0;
        m_ptr  = 0;
        m_last = 0;
        hist.delete();
        for (int i = 0; i < PN; i++) wait_n[i] = 0;
    endtask

    // One cycle: drive, compare against the model, then advance model across the edge.
    task automatic step(input logic [PN-1:0] r, input logic y, input int lit);
        int            idx;
        logic [PN-1:0] e_gnt;
        int            e_sel;
        bit            xfer;
        req = r;
        rdy = y;
        #2;
        idx = -1;
        if (m_hold) begin
            idx = m_hidx;
        end else begin
            for (int k = 0; k < PN; k++) begin
                int j;
                j = (m_ptr + k) % PN;
                if (idx < 0 && r[j]) idx = j;
            end
        end
        e_gnt = (idx >= 0) ? (PN'(1) << idx) : '0;
        e_sel = (idx >= 0) ? idx : m_last;
        xfer  = (idx >= 0) && r[idx] && y;

        check("gnt_a", int'(bus_a.gnt), int'(e_gnt));
        check("sel_a", int'(bus_a.sel), e_sel);
        check("gnt_b", int'(bus_b.gnt), int'(e_gnt));
        check("rsp_b_eq_sel", int'(bus_b.rsp_sel), e_sel);
        check("onehot_a", int'($countones(bus_a.gnt) <= 1), 1);
        if (lit >= 0) check("gnt_literal", int'(bus_a.gnt), lit);

        hist.push_back(xfer ? idx : -1);
        if (hist.size() > DLY) begin
            int h;
            h = hist[hist.size() - 1 - DLY];
            if (h >= 0) check("rsp_a_delayed", int'(bus_a.rsp_sel), h);
        end

        if (xfer) check("starve_bound", int'(wait_n[idx] < PN), 1);
        for (int i = 0; i < PN; i++) begin
            if (!r[i] || (xfer && i == idx)) wait_n[i] = 0;
            else if (xfer) wait_n[i]++;
        end

        if (xfer) begin
            m_ptr  = (idx + 1) % PN;
            m_hold = 1'b0;
        end else if (idx >= 0 && !m_hold && !y) begin
            m_hold = 1'b1;
            m_hidx = idx;
        end
        if (idx >= 0) m_last = idx;
        last_x = xfer ? idx : -1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b0;
        req  = '1;
        rdy  = 1'b1;
        req2 = 2'b11;
        rdy2 = 1'b1;
        model_reset();
        #2;
        check("rst_gnt_a", int'(bus_a.gnt), 0);
        check("rst_sel_a", int'(bus_a.sel), 0);
        check("rst_rsp_a", int'(bus_a.rsp_sel), 0);
        check("rst_rsp_b", int'(bus_b.rsp_sel), 0);
        check("rst_gnt_c", int'(bus_c.gnt), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        req  = '0;
        rdy  = 1'b0;
        rst  = 1'b1;

        // Two ports, both requesting, always ready: strict alternation.
        for (int k = 0; k < 6; k++) begin
            req2 = 2'b11;
            rdy2 = 1'b1;
            #2;
            check("alt_gnt_c", int'(bus_c.gnt), (k % 2 == 0) ? 1 : 2);
            check("alt_sel_c", int'(bus_c.sel), k % 2);
            if (k > 0) check("alt_rsp_c", int'(bus_c.rsp_sel), (k - 1) % 2);
            @(posedge clk);
            #1;
        end
        req2 = 2'b00;

        // Lock on port 0 while others pile up, then round-robin hand-off and wrap.
        step(4'b0001, 1'b0, 1);
        step(4'b0001, 1'b0, 1);
        step(4'b0001, 1'b0, 1);
        step(4'b1111, 1'b0, 1);
        step(4'b1111, 1'b1, 1);
        step(4'b1111, 1'b1, 2);
        step(4'b1100, 1'b1, 4);
        step(4'b1001, 1'b1, 8);
        step(4'b0001, 1'b1, 1);
        step(4'b0000, 1'b0, 0);
        step(4'b0000, 1'b0, 0);
        step(4'b0000, 1'b0, 0);

        // Two transfers in flight, lock on port 2, then asynchronous reset.
        step(4'b0001, 1'b1, 1);
        step(4'b0010, 1'b1, 2);
        step(4'b0100, 1'b0, 4);
        req = 4'b0100;
        rdy = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("midrst_gnt_a", int'(bus_a.gnt), 0);
        check("midrst_sel_a", int'(bus_a.sel), 0);
        check("midrst_rsp_a", int'(bus_a.rsp_sel), 0);
        check("midrst_rsp_b", int'(bus_b.rsp_sel), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(4'b0100, 1'b1, 4);
        step(4'b1010, 1'b1, 8);
        step(4'b0010, 1'b1, 2);

        // Random traffic: a raised request holds until its own transfer.
        for (int i = 0; i < PN; i++) pend[i] = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            logic [PN-1:0] r;
            for (int i = 0; i < PN; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 30) pend[i] = 1'b1;
                r[i] = pend[i];
            end
            step(r, 1'($urandom_range(0, 1)), -1);
            if (last_x >= 0) pend[last_x] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
